pwd_store: RTL

- Parametrised password storage for the keypad lock. Successor to the fixed 8-digit × 2-bit password list.
- Holds the active password and its length, and serves digits by index to the comparator.
- Runs an edit session: new digits go into a shadow buffer. The active password is replaced in one cycle only on a valid commit; abort or reject leaves it intact.

---
 rtl/pwd_pkg.sv | 16 +
 rtl/pwd_shadow_buf.sv | 82 ++++++++
 rtl/pwd_store.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pwd_pkg.sv
// Shared types and default sizing for the keypad lock password store.
// Includes the state encoding used when PWD_STORE_CONFIRM_EN adds a confirm pass.
package pwd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONFIRM = 2'd2
  } pwd_state_e;

  localparam int DIGIT_W_DEF = 2;
  localparam int MAX_LEN_DEF = 8;
  localparam int MIN_LEN_DEF = 1;
  localparam int DEF_LEN_DEF = 4;

endpackage

// File: rtl/pwd_shadow_buf.sv
// Shadow digit buffer for an edit session. It holds the digits, the write pointer and the sticky overflow flag.
// With PWD_STORE_CONFIRM_EN it also provides a compare-and-advance port for the confirm pass.
module pwd_shadow_buf
  import pwd_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
`ifdef PWD_STORE_CONFIRM_EN
  input  logic                             adv_en,
  output logic                             cmp_eq,
`endif
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [DIGIT_W-1:0]               wr_data,
  output logic [LEN_W-1:0]                 cnt,
  output logic                             ovf,
  output logic [MAX_LEN-1:0][DIGIT_W-1:0]  shadow
);

  logic [MAX_LEN-1:0][DIGIT_W-1:0] shadow_q, shadow_d;
  logic [LEN_W-1:0]                cnt_q, cnt_d;
  logic                            ovf_q, ovf_d;
  logic                            full;

  assign full = (cnt_q >= LEN_W'(MAX_LEN));

  // The pointer saturates at MAX_LEN; any further digit only raises the overflow flag.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (wr_en) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (cnt_q == LEN_W'(i)) shadow_d[i] = wr_data;
        end
        cnt_d = cnt_q + LEN_W'(1);
      end
    end
`ifdef PWD_STORE_CONFIRM_EN
    else if (adv_en) begin
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + LEN_W'(1);
    end
`endif
  end

`ifdef PWD_STORE_CONFIRM_EN
  always_comb begin
    cmp_eq = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (cnt_q == LEN_W'(i) && shadow_q[i] == wr_data) cmp_eq = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt    = cnt_q;
  assign ovf    = ovf_q;
  assign shadow = shadow_q;

endmodule

// File: rtl/pwd_store.sv
// Active password store with its edit-session FSM. A new password replaces the old one atomically only on a valid commit.
// Defining PWD_STORE_CONFIRM_EN requires the new password to be typed a second time before it is installed.
module pwd_store
  import pwd_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int DEF_LEN = DEF_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               unlocked,
  input  logic               edit_start,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_data,
  input  logic               edit_commit,
  input  logic               edit_abort,
  input  logic [LEN_W-1:0]   rd_idx,
  output logic [DIGIT_W-1:0] rd_digit,
  output logic [LEN_W-1:0]   pwd_len,
  output logic               editing,
  output logic [LEN_W-1:0]   entry_cnt,
  output logic               commit_ok,
  output logic               commit_err
);

  typedef logic [MAX_LEN-1:0][DIGIT_W-1:0] digits_t;

  pwd_state_e       state_q, state_d;
  digits_t          active_q, active_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             session_drop;
  logic             buf_clr, buf_wr, buf_ovf;
  logic [LEN_W-1:0] buf_cnt;
  digits_t          buf_shadow;
`ifdef PWD_STORE_CONFIRM_EN
  logic             buf_adv, buf_eq;
  logic             mismatch_q, mismatch_d;
  logic [LEN_W-1:0] first_len_q, first_len_d;
`endif

  function automatic digits_t keep_first(input digits_t src, input logic [LEN_W-1:0] n);
    digits_t res;
    for (int i = 0; i < MAX_LEN; i++) res[i] = (LEN_W'(i) < n) ? src[i] : '0;
    return res;
  endfunction

  assign session_drop = edit_abort || !unlocked;

  pwd_shadow_buf #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shadow (
`ifdef PWD_STORE_CONFIRM_EN
    .adv_en  (buf_adv),
    .cmp_eq  (buf_eq),
`endif
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (key_data),
    .cnt     (buf_cnt),
    .ovf     (buf_ovf),
    .shadow  (buf_shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      len_q    <= LEN_W'(DEF_LEN);
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef PWD_STORE_CONFIRM_EN
      mismatch_q  <= 1'b0;
      first_len_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      len_q    <= len_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
`ifdef PWD_STORE_CONFIRM_EN
      mismatch_q  <= mismatch_d;
      first_len_q <= first_len_d;
`endif
    end
  end

  // Abort or lock-drop outranks commit, and commit outranks a same-cycle key.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    len_d    = len_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    buf_clr  = 1'b0;
    buf_wr   = 1'b0;
`ifdef PWD_STORE_CONFIRM_EN
    buf_adv     = 1'b0;
    mismatch_d  = mismatch_q;
    first_len_d = first_len_q;
`endif
    case (state_q)
      IDLE: begin
        if (edit_start && unlocked) begin
          state_d = ENTRY;
          buf_clr = 1'b1;
        end
      end
      ENTRY: begin
        if (session_drop) begin
          state_d = IDLE;
        end else if (edit_commit) begin
          if (!buf_ovf && buf_cnt >= LEN_W'(MIN_LEN)) begin
`ifdef PWD_STORE_CONFIRM_EN
            state_d     = CONFIRM;
            buf_clr     = 1'b1;
            first_len_d = buf_cnt;
            mismatch_d  = 1'b0;
`else
            state_d  = IDLE;
            active_d = keep_first(buf_shadow, buf_cnt);
            len_d    = buf_cnt;
            ok_d     = 1'b1;
`endif
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (key_valid) begin
          buf_wr = 1'b1;
        end
      end
      CONFIRM: begin
`ifdef PWD_STORE_CONFIRM_EN
        if (session_drop) begin
          state_d = IDLE;
        end else if (edit_commit) begin
          state_d = IDLE;
          if (buf_cnt == first_len_q && !mismatch_q) begin
            active_d = keep_first(buf_shadow, first_len_q);
            len_d    = first_len_q;
            ok_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_valid) begin
          buf_adv = 1'b1;
          if (buf_cnt >= first_len_q || !buf_eq) mismatch_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_digit = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_idx == LEN_W'(i)) rd_digit = active_q[i];
    end
    pwd_len    = len_q;
    editing    = (state_q != IDLE);
    entry_cnt  = buf_cnt;
    commit_ok  = ok_q;
    commit_err = err_q;
  end

endmodule
